// File: rtl/fetch_decode_queue_pkg.sv
// rtl/fetch_decode_queue_pkg.sv - shared widths and entry layout for the fetch/decode queue
package fetch_decode_queue_pkg;

  // Default configuration of the queue
  localparam int FDQ_WORD_SIZE = 32;
  localparam int FDQ_DEPTH     = 4;

  // Entry layout: {rm0, instruction}; instruction in the low word, rm0 in the high word
  localparam int FETCH_ENTRY_W = 2 * FDQ_WORD_SIZE;
  localparam int INSTR_OFFSET  = 0;
  localparam int RM0_OFFSET    = FDQ_WORD_SIZE;
  localparam int QUEUE_PTR_W   = $clog2(FDQ_DEPTH);

  // Helpers so a re-parameterised queue derives the same layout
  function automatic int fetch_entry_w(input int word_size);
    return 2 * word_size;
  endfunction

  function automatic int rm0_offset(input int word_size);
    return word_size;
  endfunction

  function automatic int queue_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// rtl/fetch_decode_queue_mem.sv - register array with one write port and a combinational read port
module fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 64,
  parameter int PTR_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]   rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Storage is cleared on reset so the read port never returns X
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // First-word fall-through read of the addressed entry
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - buffers fetched (rm0, instruction) pairs for decode with stall and flush
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int WORD_SIZE = FDQ_WORD_SIZE,
  parameter int DEPTH     = FDQ_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               active_in,
  input  logic [WORD_SIZE-1:0]               rm0_in,
  input  logic [WORD_SIZE-1:0]               instruction_in,
  output logic                               stall_out,
  input  logic                               flush,
  input  logic                               decode_ready,
  output logic                               decode_valid,
  output logic [WORD_SIZE-1:0]               rm0_out,
  output logic [WORD_SIZE-1:0]               instruction_out,
  output logic [queue_ptr_w(DEPTH):0]        count_out,
  output logic                               overflow_out
);

  localparam int ENTRY_W = fetch_entry_w(WORD_SIZE);
  localparam int RM0_LSB = rm0_offset(WORD_SIZE);
  localparam int PTR_W   = queue_ptr_w(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               full;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Status decoded from the registered occupancy only
  always_comb begin
    full         = (count_q == FULL_COUNT);
    stall_out    = full;
    decode_valid = (count_q != '0);
    count_out    = count_q;
    overflow_out = overflow_q;
  end

  // Handshake qualification; a flush cancels both sides of the transfer
  always_comb begin
    enq      = active_in && !full && !flush;
    deq      = decode_valid && decode_ready && !flush;
    wr_entry = '0;
    wr_entry[RM0_LSB +: WORD_SIZE]      = rm0_in;
    wr_entry[INSTR_OFFSET +: WORD_SIZE] = instruction_in;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (active_in && full);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset overrides flush and abandons every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (enq),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_entry)
  );

  // Head entry is shown only while valid so an empty queue reads as zero
  always_comb begin
    rm0_out         = '0;
    instruction_out = '0;
    if (decode_valid) begin
      rm0_out         = head_entry[RM0_LSB +: WORD_SIZE];
      instruction_out = head_entry[INSTR_OFFSET +: WORD_SIZE];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        active_in;
  logic [31:0] rm0_in;
  logic [31:0] instruction_in;
  logic        stall_out;
  logic        flush;
  logic        decode_ready;
  logic        decode_valid;
  logic [31:0] rm0_out;
  logic [31:0] instruction_out;
  logic [2:0]  count_out;
  logic        overflow_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .WORD_SIZE (32),
    .DEPTH     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .active_in       (active_in),
    .rm0_in          (rm0_in),
    .instruction_in  (instruction_in),
    .stall_out       (stall_out),
    .flush           (flush),
    .decode_ready    (decode_ready),
    .decode_valid    (decode_valid),
    .rm0_out         (rm0_out),
    .instruction_out (instruction_out),
    .count_out       (count_out),
    .overflow_out    (overflow_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    active_in      = 1'b1;
    rm0_in         = addr;
    instruction_in = word;
  endtask

  // Occupancy must stay within 0..DEPTH at every sample point
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      assert (count_out <= 3'd4) else begin
        errors++;
        $error("FAIL count_range observed=%0d expected<=4", count_out);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    active_in      = 1'b0;
    rm0_in         = '0;
    instruction_in = '0;
    flush          = 1'b0;
    decode_ready   = 1'b0;
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count",    32'(count_out),    32'd0);
    check("rst_valid",    32'(decode_valid), 32'd0);
    check("rst_stall",    32'(stall_out),    32'd0);
    check("rst_overflow", 32'(overflow_out), 32'd0);
    check("rst_rm0",      rm0_out,           32'd0);
    check("rst_instr",    instruction_out,   32'd0);

    // 1: single fetch becomes visible one cycle later
    fetch(32'h100, 32'h0050_0093);
    tick();
    active_in = 1'b0;
    check("t1_valid", 32'(decode_valid), 32'd1);
    check("t1_rm0",   rm0_out,           32'h100);
    check("t1_instr", instruction_out,   32'h0050_0093);
    check("t1_count", 32'(count_out),    32'd1);
    check("t1_stall", 32'(stall_out),    32'd0);

    // 2: fill to DEPTH, then a fetch while full is dropped
    fetch(32'h104, 32'hBEEF_0104);
    tick();
    fetch(32'h108, 32'hBEEF_0108);
    tick();
    check("t2_count3", 32'(count_out), 32'd3);
    fetch(32'h10C, 32'hBEEF_010C);
    tick();
    active_in = 1'b0;
    check("t2_count_full", 32'(count_out),    32'd4);
    check("t2_stall",      32'(stall_out),    32'd1);
    check("t2_ovf_clear",  32'(overflow_out), 32'd0);
    fetch(32'h110, 32'hBEEF_0110);
    tick();
    active_in = 1'b0;
    check("t2_overflow", 32'(overflow_out), 32'd1);
    check("t2_count",    32'(count_out),    32'd4);
    check("t2_head",     rm0_out,           32'h100);

    // 3: drain in order; the first drain cycle also offers a fetch that must not enter
    decode_ready = 1'b1;
    fetch(32'h1F0, 32'hDEAD_01F0);
    tick();
    active_in = 1'b0;
    check("t3_count_after_full_deq", 32'(count_out), 32'd3);
    check("t3_stall_released",       32'(stall_out), 32'd0);
    check("t3_head1",  rm0_out,         32'h104);
    check("t3_instr1", instruction_out, 32'hBEEF_0104);
    tick();
    check("t3_head2",  rm0_out,         32'h108);
    check("t3_instr2", instruction_out, 32'hBEEF_0108);
    tick();
    check("t3_head3",  rm0_out,         32'h10C);
    check("t3_instr3", instruction_out, 32'hBEEF_010C);
    tick();
    decode_ready = 1'b0;
    check("t3_empty_valid", 32'(decode_valid), 32'd0);
    check("t3_empty_count", 32'(count_out),    32'd0);
    check("t3_empty_rm0",   rm0_out,           32'd0);
    check("t3_empty_instr", instruction_out,   32'd0);

    // 4: steady stream; one entry in flight, order kept through pointer wrap
    decode_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch(32'h200 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
      tick();
      check("t4_count", 32'(count_out),   32'd1);
      check("t4_rm0",   rm0_out,          32'h200 + 32'(4 * i));
      check("t4_instr", instruction_out,  32'hCAFE_0000 + 32'(i));
    end
    active_in = 1'b0;
    tick();
    decode_ready = 1'b0;
    check("t4_drained", 32'(count_out), 32'd0);

    // 5: flush with a same-cycle fetch discards everything
    fetch(32'h400, 32'h0000_0400);
    tick();
    fetch(32'h404, 32'h0000_0404);
    tick();
    fetch(32'h408, 32'h0000_0408);
    tick();
    check("t5_count3", 32'(count_out), 32'd3);
    check("t5_head",   rm0_out,        32'h400);
    fetch(32'h300, 32'h0000_0300);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    active_in = 1'b0;
    check("t5_count",    32'(count_out),    32'd0);
    check("t5_valid",    32'(decode_valid), 32'd0);
    check("t5_rm0",      rm0_out,           32'd0);
    check("t5_overflow", 32'(overflow_out), 32'd1);
    tick();
    check("t5_no_300", 32'(count_out), 32'd0);
    fetch(32'h440, 32'h0000_0440);
    tick();
    active_in = 1'b0;
    check("t5_refill_rm0", rm0_out, 32'h440);

    // 6: reset beats flush and clears the sticky flag
    fetch(32'h444, 32'h0000_0444);
    tick();
    active_in = 1'b0;
    check("t6_count2", 32'(count_out), 32'd2);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    check("t6_count",    32'(count_out),    32'd0);
    check("t6_overflow", 32'(overflow_out), 32'd0);
    check("t6_valid",    32'(decode_valid), 32'd0);
    check("t6_rm0",      rm0_out,           32'd0);
    check("t6_instr",    instruction_out,   32'd0);
    fetch(32'h500, 32'h1234_5678);
    tick();
    active_in = 1'b0;
    check("t6_after_count", 32'(count_out),    32'd1);
    check("t6_after_valid", 32'(decode_valid), 32'd1);
    check("t6_after_rm0",   rm0_out,           32'h500);
    check("t6_after_instr", instruction_out,   32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
